// File: rtl/kernel_3x3_window_strided.sv
// 3x3 sliding-window generator over a raster pixel stream, with runtime stride 1/2.
// Two column-indexed row buffers supply the two rows above the incoming pixel.
module kernel_3x3_window_strided #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 299,
    parameter int IMG_HEIGHT = 299
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_in,
    input  logic                  Stride_Sel,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
    output logic [DATA_WIDTH-1:0] Data_Out9,
    output logic                  Valid_Out,
    output logic                  Last_Out,
    output logic                  Frame_Done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST2 = CW'(2 + 2 * ((IMG_WIDTH - 3) / 2));
    localparam logic [RW-1:0] ROW_LAST2 = RW'(2 + 2 * ((IMG_HEIGHT - 3) / 2));

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  stride2;
    logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] tap   [9];
    logic [DATA_WIDTH-1:0] above1;
    logic [DATA_WIDTH-1:0] above2;
    logic                  col_end;
    logic                  row_end;
    logic                  win;
    logic                  last_win;

    // Reading at the current column yields the pixel exactly one (two) rows earlier.
    assign above1 = line1[col];
    assign above2 = line2[col];

    always_comb begin
        col_end  = (col == COL_MAX);
        row_end  = (row == ROW_MAX);
        win      = (row >= RW'(2)) && (col >= CW'(2)) && (!stride2 || (!col[0] && !row[0]));
        last_win = stride2 ? ((col == COL_LAST2) && (row == ROW_LAST2)) : (col_end && row_end);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            stride2    <= 1'b0;
            Valid_Out  <= 1'b0;
            Last_Out   <= 1'b0;
            Frame_Done <= 1'b0;
            for (int i = 0; i < 9; i++) tap[i] <= '0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                line1[i] <= '0;
                line2[i] <= '0;
            end
        end else begin
            Valid_Out  <= Valid_in && win;
            Last_Out   <= Valid_in && win && last_win;
            Frame_Done <= Valid_in && col_end && row_end;
            if (Valid_in) begin
                line1[col] <= Data_In;
                line2[col] <= above1;
                tap[0] <= tap[1];
                tap[1] <= tap[2];
                tap[2] <= above2;
                tap[3] <= tap[4];
                tap[4] <= tap[5];
                tap[5] <= above1;
                tap[6] <= tap[7];
                tap[7] <= tap[8];
                tap[8] <= Data_In;
                // The stride for the whole frame is captured on its first pixel only.
                if (col == '0 && row == '0) stride2 <= Stride_Sel;
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign Data_Out1 = tap[0];
    assign Data_Out2 = tap[1];
    assign Data_Out3 = tap[2];
    assign Data_Out4 = tap[3];
    assign Data_Out5 = tap[4];
    assign Data_Out6 = tap[5];
    assign Data_Out7 = tap[6];
    assign Data_Out8 = tap[7];
    assign Data_Out9 = tap[8];
endmodule

// File: tb/tb_kernel_3x3_window_strided.sv
// Directed bench for the 3x3 window generator on an 8x6 frame.
// A position-indexed image model predicts each window; predictions go through a queue.
module tb_kernel_3x3_window_strided;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int TW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] Data_In = '0;
    logic          Valid_in = 1'b0;
    logic          Stride_Sel = 1'b0;
    logic [DW-1:0] Data_Out1, Data_Out2, Data_Out3, Data_Out4, Data_Out5;
    logic [DW-1:0] Data_Out6, Data_Out7, Data_Out8, Data_Out9;
    logic          Valid_Out, Last_Out, Frame_Done;

    kernel_3x3_window_strided #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_in(Valid_in), .Stride_Sel(Stride_Sel),
        .Data_Out1(Data_Out1), .Data_Out2(Data_Out2), .Data_Out3(Data_Out3),
        .Data_Out4(Data_Out4), .Data_Out5(Data_Out5), .Data_Out6(Data_Out6),
        .Data_Out7(Data_Out7), .Data_Out8(Data_Out8), .Data_Out9(Data_Out9),
        .Valid_Out(Valid_Out), .Last_Out(Last_Out), .Frame_Done(Frame_Done)
    );

    always #5 clk = ~clk;

    int            vecs = 0;
    int            errs = 0;
    logic [TW-1:0] exp_q[$];
    logic [DW-1:0] img[IH][IW];
    int            m_col = 0;
    int            m_row = 0;
    logic          m_s2 = 1'b0;
    logic          hold_ok = 1'b0;
    logic [TW-1:0] hold_word = '0;
    int            win_cnt = 0;
    logic [TW-1:0] first_word = '0;
    logic          first_seen = 1'b0;

    function automatic logic [TW-1:0] dut_taps();
        return {Data_Out1, Data_Out2, Data_Out3, Data_Out4, Data_Out5,
                Data_Out6, Data_Out7, Data_Out8, Data_Out9};
    endfunction

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_s2 = 1'b0;
        hold_ok = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, predict, let the edge happen, then check outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic s);
        logic          exp_v, exp_l, exp_fd;
        logic [TW-1:0] w, got_exp;
        exp_v = 1'b0;
        exp_l = 1'b0;
        exp_fd = 1'b0;
        w = '0;
        Valid_in = v;
        Data_In = d;
        Stride_Sel = s;
        if (v) begin
            if (m_col == 0 && m_row == 0) m_s2 = s;
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2 && (!m_s2 || (m_col % 2 == 0 && m_row % 2 == 0))) begin
                exp_v = 1'b1;
                w = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                     img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                     img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
                exp_q.push_back(w);
                if (m_s2) exp_l = (m_col == 2 + 2 * ((IW - 3) / 2)) && (m_row == 2 + 2 * ((IH - 3) / 2));
                else      exp_l = (m_col == IW - 1) && (m_row == IH - 1);
            end
            exp_fd = (m_col == IW - 1) && (m_row == IH - 1);
            if (m_col == IW - 1) begin
                m_col = 0;
                m_row = (m_row == IH - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        @(posedge clk);
        #1;
        check("valid_out", TW'(Valid_Out), TW'(exp_v));
        check("last_out", TW'(Last_Out), TW'(exp_l));
        check("frame_done", TW'(Frame_Done), TW'(exp_fd));
        if (exp_v && exp_q.size() > 0) begin
            got_exp = exp_q.pop_front();
            if (Valid_Out) begin
                check("window_taps", dut_taps(), got_exp);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_word = dut_taps();
                end
            end
        end
        if (!v && hold_ok) check("taps_held", dut_taps(), hold_word);
        if (v) begin
            hold_ok = exp_v;
            hold_word = w;
        end
        if (Valid_Out) win_cnt++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        Valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset_taps", dut_taps(), '0);
            check("reset_flags", TW'({Valid_Out, Last_Out, Frame_Done}), '0);
        end
        rst = 1'b1;
        model_reset();
    endtask

    // Sends pixels [0, count) of a frame; Stride_Sel flips at pixel switch_at (if >= 0).
    task automatic send_frame(input int base, input logic s_first, input int switch_at,
                              input int gap_pct, input int count, input int exp_windows);
        logic s;
        win_cnt = 0;
        first_seen = 1'b0;
        for (int i = 0; i < count; i++) begin
            s = (switch_at >= 0 && i >= switch_at) ? ~s_first : s_first;
            for (int g = 0; g < 6 && $urandom_range(99) < gap_pct; g++)
                step(1'b0, DW'($urandom), s);
            step(1'b1, DW'(base + i), s);
        end
        Valid_in = 1'b0;
        if (exp_windows >= 0) check("window_count", TW'(win_cnt), TW'(exp_windows));
    endtask

    function automatic logic [TW-1:0] first_window(input int base);
        return {DW'(base + 0),  DW'(base + 1),  DW'(base + 2),
                DW'(base + 8),  DW'(base + 9),  DW'(base + 10),
                DW'(base + 16), DW'(base + 17), DW'(base + 18)};
    endfunction

    initial begin
        do_reset(3);

        // Stride 1, back-to-back pixels
        send_frame(0, 1'b0, -1, 0, IW * IH, 24);
        check("first_window_s1", first_word, first_window(0));

        // Stride 2 on the same frame
        send_frame(0, 1'b1, -1, 0, IW * IH, 6);
        check("first_window_s2", first_word, first_window(0));

        // Stride 1 with random input gaps
        send_frame(0, 1'b0, -1, 40, IW * IH, 24);
        check("first_window_gaps", first_word, first_window(0));

        // Stride_Sel drops mid-frame: stride 2 must persist, then next frame is stride 1
        send_frame(0, 1'b1, 20, 0, IW * IH, 6);
        send_frame(0, 1'b0, -1, 0, IW * IH, 24);

        // Back-to-back frames with no idle cycle
        send_frame(0, 1'b0, -1, 0, IW * IH, 24);
        send_frame(100, 1'b0, -1, 0, IW * IH, 24);
        check("first_window_frame2", first_word, first_window(100));

        // Reset mid-frame, then a fresh frame
        send_frame(0, 1'b0, -1, 0, 26, -1);
        do_reset(1);
        send_frame(0, 1'b0, -1, 0, IW * IH, 24);
        check("first_window_after_reset", first_word, first_window(0));

        check("queue_empty", TW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
